// File: rtl/push_button_conditioner.sv
// push_button_conditioner: conditions raw push buttons into clean debounced levels plus
// one-cycle press and release pulses. Each button has its own 2-flop synchroniser and its
// own debounce counter; buttons never interact.
// Optional feature: define PUSH_AUTOREPEAT_EN to add per-button auto-repeat press pulses
// while a button stays held (REPEAT_DELAY to the first repeat, then every REPEAT_RATE).
module push_button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned REPEAT_DELAY    = 2**24,
  parameter int unsigned REPEAT_RATE     = 2**22
) (
  input  logic             clk_osc,
  input  logic             reset,
  input  logic [N_BTN-1:0] push,
  output logic [N_BTN-1:0] push_level,
  output logic [N_BTN-1:0] push_pulse,
  output logic [N_BTN-1:0] push_release
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] pulse_q, release_q;
  logic [CntW-1:0]  cnt_q [N_BTN];

  logic [N_BTN-1:0] accept, rise, fall;
  logic [N_BTN-1:0] rpt_fire;

  // A level change is accepted on the cycle the mismatch run reaches its full length.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CntLast);
    end
    rise = accept & sync2_q;
    fall = accept & ~sync2_q;
  end

  // Synchroniser, debounce counters, accepted level and registered pulses.
  always_ff @(posedge clk_osc) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pulse_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= push;
      sync2_q <= sync1_q;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          // Any agreeing sample discards a partial run.
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      pulse_q   <= rise | rpt_fire;
      release_q <= fall;
    end
  end

`ifdef PUSH_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = (RptMax > 2) ? $clog2(RptMax) : 1;
  localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

  logic [RptW-1:0]  rpt_cnt_q [N_BTN];
  logic [N_BTN-1:0] rpt_phase_q;  // 0: waiting for first repeat, 1: steady repeat rate

  // Repeat fires while held; a release accepted this cycle suppresses it.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_fire[i] = stable_q[i] && !fall[i] &&
                    (rpt_cnt_q[i] == (rpt_phase_q[i] ? RateLast : DelayLast));
    end
  end

  // Repeat timers count only while the accepted level is high.
  always_ff @(posedge clk_osc) begin
    if (reset) begin
      rpt_phase_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!stable_q[i] || fall[i]) begin
          rpt_cnt_q[i]   <= '0;
          rpt_phase_q[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rpt_cnt_q[i]   <= '0;
          rpt_phase_q[i] <= 1'b1;
        end else begin
          rpt_cnt_q[i] <= rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  assign push_level   = stable_q;
  assign push_pulse   = pulse_q;
  assign push_release = release_q;

endmodule
